// File: rtl/ftoi_pipe.sv
// Pipelined float32 -> INT_W-bit integer converter with valid/ready flow control.
// Optional macro FTOI_STICKY_FLAGS_EN adds flag_clr and sticky nv/nx flag outputs.
module ftoi_pipe #(
  parameter int INT_W  = 32,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
`ifdef FTOI_STICKY_FLAGS_EN
  input  logic             flag_clr,
  output logic             flag_nv_sticky,
  output logic             flag_nx_sticky,
`endif
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      x,
  input  logic [1:0]       rm,
  input  logic             is_unsigned,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [INT_W-1:0] y,
  output logic             nv,
  output logic             nx
);

  localparam int W = INT_W + 25;
  localparam logic [7:0]     OVF_E = 8'(127 + INT_W);
  localparam logic [INT_W:0] HALF  = {2'b01, {(INT_W-1){1'b0}}};
  localparam logic [INT_W-1:0] MAXS = {1'b0, {(INT_W-1){1'b1}}};
  localparam logic [INT_W-1:0] MINS = {1'b1, {(INT_W-1){1'b0}}};

  typedef enum logic [1:0] {
    RM_RNA = 2'b00,
    RM_RTZ = 2'b01,
    RM_RNE = 2'b10,
    RM_RDN = 2'b11
  } rm_e;

  typedef struct packed {
    logic             s;
    logic [INT_W-1:0] mag;
    logic             g;
    logic             st;
    logic             nan;
    logic             big;
    rm_e              rm;
    logic             uns;
  } align_t;

  // ---------------- alignment ----------------
  logic [7:0]   e;
  logic [22:0]  m;
  logic [23:0]  mant;
  logic [7:0]   sh;
  logic [W-1:0] field;
  align_t       a_in;

  always_comb begin
    a_in  = '0;
    e     = x[30:23];
    m     = x[22:0];
    mant  = {e != 8'd0, m};
    sh    = e - 8'd126;
    // binary point sits between field[24] and field[23]
    field = {{(W-24){1'b0}}, mant} << sh;
    a_in.s   = x[31];
    a_in.rm  = rm_e'(rm);
    a_in.uns = is_unsigned;
    a_in.nan = (e == 8'hFF) && (m != '0);
    a_in.big = ((e == 8'hFF) && (m == '0)) ||
               ((e != 8'hFF) && (e >= OVF_E || field[W-1]));
    if (e < 8'd126) begin
      a_in.st = |mant;
    end else if (!a_in.nan && !a_in.big) begin
      a_in.mag = field[INT_W+23:24];
      a_in.g   = field[23];
      a_in.st  = |field[22:0];
    end
  end

  // ---------------- flow control ----------------
  logic [STAGES-1:0] v;
  logic [STAGES-1:0] ld;
  logic              acc;

  always_comb begin
    ld  = '0;
    acc = out_ready;
    for (int unsigned k = 0; k < STAGES; k++) begin
      acc              = !v[STAGES-1-k] || acc;
      ld[STAGES-1-k]   = acc;
    end
  end

  assign in_ready  = ld[0];
  assign out_valid = v[STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      v <= '0;
    end else begin
      if (ld[0]) v[0] <= in_valid;
      for (int unsigned k = 1; k < STAGES; k++)
        if (ld[k]) v[k] <= v[k-1];
    end
  end

  // ---------------- alignment registers ----------------
  align_t a_last;

  generate
    if (STAGES == 1) begin : g_direct
      assign a_last = a_in;
    end else begin : g_regs
      align_t a_q [STAGES-1];
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int unsigned i = 0; i < STAGES-1; i++) a_q[i] <= '0;
        end else begin
          if (ld[0]) a_q[0] <= a_in;
          for (int unsigned i = 1; i < STAGES-1; i++)
            if (ld[i]) a_q[i] <= a_q[i-1];
        end
      end
      assign a_last = a_q[STAGES-2];
    end
  endgenerate

  // ---------------- round / saturate / negate ----------------
  logic             inc;
  logic             nx_raw;
  logic [INT_W:0]   mag_r;
  logic [INT_W:0]   neg;
  logic [INT_W-1:0] y_d;
  logic             nv_d;
  logic             nx_d;

  always_comb begin
    case (a_last.rm)
      RM_RNA:  inc = a_last.g;
      RM_RTZ:  inc = 1'b0;
      RM_RNE:  inc = a_last.g && (a_last.st || a_last.mag[0]);
      RM_RDN:  inc = a_last.s && (a_last.g || a_last.st);
      default: inc = 1'b0;
    endcase
    nx_raw = a_last.g || a_last.st;
    mag_r  = {1'b0, a_last.mag} + {{INT_W{1'b0}}, inc};
    neg    = '0 - mag_r;
    y_d    = '0;
    nv_d   = 1'b0;
    if (a_last.nan) begin
      nv_d = 1'b1;
      y_d  = a_last.uns ? '1 : MAXS;
    end else if (a_last.big) begin
      nv_d = 1'b1;
      if (a_last.s) y_d = a_last.uns ? '0 : MINS;
      else          y_d = a_last.uns ? '1 : MAXS;
    end else if (!a_last.s) begin
      if (a_last.uns) begin
        if (mag_r[INT_W]) begin nv_d = 1'b1; y_d = '1; end
        else              y_d = mag_r[INT_W-1:0];
      end else begin
        if (mag_r >= HALF) begin nv_d = 1'b1; y_d = MAXS; end
        else               y_d = mag_r[INT_W-1:0];
      end
    end else begin
      if (a_last.uns) begin
        nv_d = (mag_r != '0);
      end else begin
        if (mag_r > HALF) begin nv_d = 1'b1; y_d = MINS; end
        else              y_d = neg[INT_W-1:0];
      end
    end
    nx_d = nx_raw && !nv_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      y  <= '0;
      nv <= 1'b0;
      nx <= 1'b0;
    end else if (ld[STAGES-1]) begin
      y  <= y_d;
      nv <= nv_d;
      nx <= nx_d;
    end
  end

`ifdef FTOI_STICKY_FLAGS_EN
  // a setting transfer overrides a simultaneous clear
  always_ff @(posedge clk) begin
    if (rst) begin
      flag_nv_sticky <= 1'b0;
      flag_nx_sticky <= 1'b0;
    end else begin
      flag_nv_sticky <= (flag_nv_sticky && !flag_clr) || (out_valid && out_ready && nv);
      flag_nx_sticky <= (flag_nx_sticky && !flag_clr) || (out_valid && out_ready && nx);
    end
  end
`endif

endmodule

// File: tb/tb_ftoi_pipe.sv
// Directed self-checking bench for ftoi_pipe: INT_W=32 and INT_W=16 instances, STAGES=2.
module tb_ftoi_pipe;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic        is_unsigned = 1'b0;
  logic [31:0] x = '0;
  logic [1:0]  rm = '0;

  logic        ir32, ov32, nv32, nx32;
  logic [31:0] y32;
  logic        ir16, ov16, nv16, nx16;
  logic [15:0] y16;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

`ifdef FTOI_STICKY_FLAGS_EN
  logic flag_clr = 1'b0;
  logic fnv32, fnx32, fnv16, fnx16;
`endif

  ftoi_pipe #(.INT_W(32), .STAGES(2)) dut32 (
    .clk(clk), .rst(rst),
`ifdef FTOI_STICKY_FLAGS_EN
    .flag_clr(flag_clr), .flag_nv_sticky(fnv32), .flag_nx_sticky(fnx32),
`endif
    .in_valid(in_valid), .in_ready(ir32), .x(x), .rm(rm), .is_unsigned(is_unsigned),
    .out_valid(ov32), .out_ready(out_ready), .y(y32), .nv(nv32), .nx(nx32)
  );

  ftoi_pipe #(.INT_W(16), .STAGES(2)) dut16 (
    .clk(clk), .rst(rst),
`ifdef FTOI_STICKY_FLAGS_EN
    .flag_clr(flag_clr), .flag_nv_sticky(fnv16), .flag_nx_sticky(fnx16),
`endif
    .in_valid(in_valid), .in_ready(ir16), .x(x), .rm(rm), .is_unsigned(is_unsigned),
    .out_valid(ov16), .out_ready(out_ready), .y(y16), .nv(nv16), .nx(nx16)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  logic [31:0] ry;
  logic        rnv, rnx;
  logic [15:0] ry16;
  logic        rnv16, rnx16;
  int          lat;

  task automatic run(input logic [31:0] xv, input logic [1:0] rmv, input logic uv);
    x = xv; rm = rmv; is_unsigned = uv; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!ov32 && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    ry = y32; rnv = nv32; rnx = nx32;
    ry16 = y16; rnv16 = nv16; rnx16 = nx16;
    @(posedge clk); #1;
  endtask

  task automatic step(input string tag, input logic [31:0] xv, input logic [1:0] rmv,
                      input logic uv, input logic [31:0] ey, input logic env, input logic enx);
    run(xv, rmv, uv);
    check({tag, "_lat"}, lat, 2);
    check({tag, "_y"}, ry, ey);
    check({tag, "_nv"}, {31'b0, rnv}, {31'b0, env});
    check({tag, "_nx"}, {31'b0, rnx}, {31'b0, enx});
  endtask

  task automatic step16(input string tag, input logic [31:0] xv, input logic [1:0] rmv,
                        input logic uv, input logic [15:0] ey, input logic env, input logic enx);
    run(xv, rmv, uv);
    check({tag, "_y"}, {16'b0, ry16}, {16'b0, ey});
    check({tag, "_nv"}, {31'b0, rnv16}, {31'b0, env});
    check({tag, "_nx"}, {31'b0, rnx16}, {31'b0, enx});
  endtask

  logic [31:0] xs [6] = '{32'h3F800000, 32'h40000000, 32'h40400000,
                          32'h40800000, 32'h40A00000, 32'h40C00000};
  logic [31:0] es [6] = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6};

  initial begin
    int  sent, recv, cyc, occ;
    logic acc_t, drn_t;

    repeat (2) @(posedge clk);
    #1;
    check("rst_ov", {31'b0, ov32}, 32'd0);
    check("rst_y", y32, 32'd0);
    check("rst_nv", {31'b0, nv32}, 32'd0);
    check("rst_nx", {31'b0, nx32}, 32'd0);
    check("rst_ir", {31'b0, ir32}, 32'd1);
    rst = 1'b0;
    @(posedge clk); #1;

    // rounding modes on 2.5, 1.5, -0.5, -2.5
    step("p25_rna", 32'h40200000, 2'b00, 1'b0, 32'd3, 1'b0, 1'b1);
    step("p25_rtz", 32'h40200000, 2'b01, 1'b0, 32'd2, 1'b0, 1'b1);
    step("p25_rne", 32'h40200000, 2'b10, 1'b0, 32'd2, 1'b0, 1'b1);
    step("p25_rdn", 32'h40200000, 2'b11, 1'b0, 32'd2, 1'b0, 1'b1);
    step("p15_rne", 32'h3FC00000, 2'b10, 1'b0, 32'd2, 1'b0, 1'b1);
    step("m05_rna", 32'hBF000000, 2'b00, 1'b0, 32'hFFFFFFFF, 1'b0, 1'b1);
    step("m05_rdn", 32'hBF000000, 2'b11, 1'b0, 32'hFFFFFFFF, 1'b0, 1'b1);
    step("m05_rne", 32'hBF000000, 2'b10, 1'b0, 32'd0, 1'b0, 1'b1);
    step("m05_rtz", 32'hBF000000, 2'b01, 1'b0, 32'd0, 1'b0, 1'b1);
    step("m25_rdn", 32'hC0200000, 2'b11, 1'b0, 32'hFFFFFFFD, 1'b0, 1'b1);

    // signed bounds and specials
    step("p2e31", 32'h4F000000, 2'b10, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b0);
    step("m2e31", 32'hCF000000, 2'b10, 1'b0, 32'h80000000, 1'b0, 1'b0);
    step("maxexact", 32'h4EFFFFFF, 2'b10, 1'b0, 32'h7FFFFF80, 1'b0, 1'b0);
    step("nan_s", 32'h7FC00000, 2'b00, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b0);
    step("minf_s", 32'hFF800000, 2'b00, 1'b0, 32'h80000000, 1'b1, 1'b0);
    step("mzero_s", 32'h80000000, 2'b00, 1'b0, 32'd0, 1'b0, 1'b0);

    // unsigned mode
    step("m2_u", 32'hC0000000, 2'b10, 1'b1, 32'd0, 1'b1, 1'b0);
    step("m025_u", 32'hBE800000, 2'b10, 1'b1, 32'd0, 1'b0, 1'b1);
    step("p2e32_u", 32'h4F800000, 2'b10, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0);
    step("nan_u", 32'hFFC00000, 2'b10, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0);
    step("zero_u", 32'h00000000, 2'b00, 1'b1, 32'd0, 1'b0, 1'b0);

    // INT_W=16 instance
    step16("w16_rna", 32'h46FFFF00, 2'b00, 1'b0, 16'h7FFF, 1'b1, 1'b0);
    step16("w16_rtz", 32'h46FFFF00, 2'b01, 1'b0, 16'h7FFF, 1'b0, 1'b1);
    step16("w16_min", 32'hC7000000, 2'b10, 1'b0, 16'h8000, 1'b0, 1'b0);
    step16("w16_nan", 32'h7FC00000, 2'b10, 1'b0, 16'h7FFF, 1'b1, 1'b0);

    // stream of 6 with out_ready pattern 1,0,0,0,1,1,...
    sent = 0; recv = 0; cyc = 0; occ = -1;
    rm = 2'b10; is_unsigned = 1'b0;
    while (recv < 6 && cyc < 60) begin
      in_valid  = (sent < 6);
      x         = (sent < 6) ? xs[sent] : 32'h0;
      out_ready = (cyc == 0) || (cyc >= 4);
      @(negedge clk);
      if (!ir32 && occ < 0) occ = sent - recv;
      if (ov32) check("pipe_y", y32, es[recv]);
      acc_t = in_valid && ir32;
      drn_t = ov32 && out_ready;
      @(posedge clk); #1;
      if (acc_t) sent++;
      if (drn_t) recv++;
      cyc++;
    end
    in_valid = 1'b0;
    check("pipe_recv", recv, 32'd6);
    check("pipe_sent", sent, 32'd6);
    check("pipe_occ", occ, 32'd2);
    repeat (3) begin
      @(negedge clk);
      check("pipe_dup", {31'b0, ov32}, 32'd0);
    end
    @(posedge clk); #1;

    // reset with two operands in flight
    out_ready = 1'b0;
    x = 32'h40E00000; in_valid = 1'b1;
    @(posedge clk); #1;
    x = 32'h41000000;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("flight_ov", {31'b0, ov32}, 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mrst_ov", {31'b0, ov32}, 32'd0);
    check("mrst_ir", {31'b0, ir32}, 32'd1);
    check("mrst_y", y32, 32'd0);
    out_ready = 1'b1;
    repeat (6) begin
      @(negedge clk);
      check("mrst_ghost", {31'b0, ov32}, 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
